// File: rtl/lsu_pma_region_checker_if.sv
// Checker bus: LSU access channels, region-table config port, registered responses.
// master = LSU/config side; slave = lsu_pma_region_checker.
interface lsu_pma_region_checker_if #(
  parameter int PADDR_W   = 56,
  parameter int NUM_CH    = 2,
  parameter int REG_IDX_W = 2
);
  logic                          flush;
  logic [NUM_CH-1:0]             ch_vld_i;
  logic [NUM_CH-1:0]             ch_dtlb_hit_i;
  logic [NUM_CH*PADDR_W-1:0]     ch_paddr_i;
  logic [NUM_CH-1:0]             ch_is_st_i;
  logic [NUM_CH-1:0]             ch_is_amo_i;
  logic                          cfg_we_i;
  logic [REG_IDX_W-1:0]          cfg_idx_i;
  logic [PADDR_W-1:0]            cfg_base_i;
  logic [PADDR_W-1:0]            cfg_limit_i;
  logic [6:0]                    cfg_attr_i;
  logic [2*PADDR_W+6:0]          cfg_rdata_o;
  logic [NUM_CH-1:0]             resp_vld_o;
  logic [NUM_CH-1:0]             resp_is_io_o;
  logic [NUM_CH-1:0]             resp_cacheable_o;
  logic [NUM_CH-1:0]             resp_fault_o;
  logic [NUM_CH*REG_IDX_W-1:0]   resp_region_o;
  logic [NUM_CH-1:0]             resp_hit_o;

  modport master (
    output flush, ch_vld_i, ch_dtlb_hit_i, ch_paddr_i,
    output ch_is_st_i, ch_is_amo_i,
    output cfg_we_i, cfg_idx_i, cfg_base_i, cfg_limit_i, cfg_attr_i,
    input  cfg_rdata_o,
    input  resp_vld_o, resp_is_io_o, resp_cacheable_o,
    input  resp_fault_o, resp_region_o, resp_hit_o
  );

  modport slave (
    input  flush, ch_vld_i, ch_dtlb_hit_i, ch_paddr_i,
    input  ch_is_st_i, ch_is_amo_i,
    input  cfg_we_i, cfg_idx_i, cfg_base_i, cfg_limit_i, cfg_attr_i,
    output cfg_rdata_o,
    output resp_vld_o, resp_is_io_o, resp_cacheable_o,
    output resp_fault_o, resp_region_o, resp_hit_o
  );
endinterface

// File: rtl/lsu_pma_region_checker.sv
// PMA region checker: programmable region table, NUM_CH parallel checks, 1-cycle resp.
// Ports: clk, rst (sync, active-high), bus (slave modport: channels, cfg, resp).
module lsu_pma_region_checker #(
  parameter int               PADDR_W     = 56,
  parameter int               NUM_REGIONS = 4,
  parameter int               NUM_CH      = 2,
  parameter logic [PADDR_W-1:0] DEF_IO_LOW = 56'h0000_1000_0000,
  parameter logic [PADDR_W-1:0] DEF_IO_UPP = 56'h0000_2000_0000,
  parameter logic [6:0]       DEF_ATTR    = 7'h17,
  parameter int               REG_IDX_W   =
    (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input logic clk,
  input logic rst,
  lsu_pma_region_checker_if.slave bus
);

  localparam int A_EN  = 6;
  localparam int A_L   = 5;
  localparam int A_C   = 4;
  localparam int A_IO  = 3;
  localparam int A_AMO = 2;
  localparam int A_W   = 1;
  localparam int A_R   = 0;

  localparam logic [6:0] RST_ATTR0 = 7'h4B;

  logic [PADDR_W-1:0] base_q  [NUM_REGIONS];
  logic [PADDR_W-1:0] limit_q [NUM_REGIONS];
  logic [6:0]         attr_q  [NUM_REGIONS];

  logic idx_ok;
  logic wr_ok;

  assign idx_ok = int'(bus.cfg_idx_i) < NUM_REGIONS;
  assign wr_ok  = bus.cfg_we_i && idx_ok &&
                  !attr_q[bus.cfg_idx_i][A_L];

  // A locked entry stays frozen until reset; L can be set
  // in the same write that loads the final contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
        base_q[r]  <= '0;
        limit_q[r] <= '0;
        attr_q[r]  <= '0;
      end
      base_q[0]  <= DEF_IO_LOW;
      limit_q[0] <= DEF_IO_UPP;
      attr_q[0]  <= RST_ATTR0;
    end else if (wr_ok) begin
      base_q[bus.cfg_idx_i]  <= bus.cfg_base_i;
      limit_q[bus.cfg_idx_i] <= bus.cfg_limit_i;
      attr_q[bus.cfg_idx_i]  <= bus.cfg_attr_i;
    end
  end

  logic [2*PADDR_W+6:0] rdata_c;

  always_comb begin
    rdata_c = '0;
    if (idx_ok) begin
      rdata_c = {base_q[bus.cfg_idx_i],
                 limit_q[bus.cfg_idx_i],
                 attr_q[bus.cfg_idx_i]};
    end
  end

  assign bus.cfg_rdata_o = rdata_c;

  logic [PADDR_W-1:0]   pa       [NUM_CH];
  logic [6:0]           sel_attr [NUM_CH];
  logic [REG_IDX_W-1:0] sel_idx  [NUM_CH];
  logic [NUM_CH-1:0]    sel_hit;
  logic [NUM_CH-1:0]    io_c;
  logic [NUM_CH-1:0]    cach_c;
  logic [NUM_CH-1:0]    fault_c;

  // Scan from the top so the lowest matching index is the
  // last one written and therefore wins.
  always_comb begin
    sel_hit = '0;
    io_c    = '0;
    cach_c  = '0;
    fault_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pa[c]       = bus.ch_paddr_i[c*PADDR_W +: PADDR_W];
      sel_attr[c] = DEF_ATTR;
      sel_idx[c]  = '0;
      for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
        if (attr_q[r][A_EN] &&
            base_q[r] <= pa[c] &&
            pa[c] < limit_q[r]) begin
          sel_attr[c] = attr_q[r];
          sel_idx[c]  = REG_IDX_W'(r);
          sel_hit[c]  = 1'b1;
        end
      end
      io_c[c]   = sel_attr[c][A_IO];
      cach_c[c] = sel_attr[c][A_C] & ~sel_attr[c][A_IO];
      if (bus.ch_is_amo_i[c]) begin
        fault_c[c] = ~(sel_attr[c][A_R] &
                       sel_attr[c][A_W] &
                       sel_attr[c][A_AMO]);
      end else if (bus.ch_is_st_i[c]) begin
        fault_c[c] = ~sel_attr[c][A_W];
      end else begin
        fault_c[c] = ~sel_attr[c][A_R];
      end
    end
  end

  logic [NUM_CH-1:0]           vld_q;
  logic [NUM_CH-1:0]           io_q;
  logic [NUM_CH-1:0]           cach_q;
  logic [NUM_CH-1:0]           fault_q;
  logic [NUM_CH-1:0]           hit_q;
  logic [NUM_CH*REG_IDX_W-1:0] region_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      io_q     <= '0;
      cach_q   <= '0;
      fault_q  <= '0;
      hit_q    <= '0;
      region_q <= '0;
    end else begin
      vld_q   <= bus.ch_vld_i & bus.ch_dtlb_hit_i &
                 {NUM_CH{~bus.flush}};
      io_q    <= io_c;
      cach_q  <= cach_c;
      fault_q <= fault_c;
      hit_q   <= sel_hit;
      for (int c = 0; c < NUM_CH; c++) begin
        region_q[c*REG_IDX_W +: REG_IDX_W] <= sel_idx[c];
      end
    end
  end

  assign bus.resp_vld_o       = vld_q;
  assign bus.resp_is_io_o     = io_q;
  assign bus.resp_cacheable_o = cach_q;
  assign bus.resp_fault_o     = fault_q;
  assign bus.resp_hit_o       = hit_q;
  assign bus.resp_region_o    = region_q;

endmodule

// File: tb/tb_lsu_pma_region_checker.sv
// Bench for lsu_pma_region_checker: directed scenarios plus random traffic
// compared against a behavioural region-table model.
module tb_lsu_pma_region_checker;

  localparam int PW = 56;
  localparam int NR = 4;
  localparam int NC = 2;
  localparam int RW = 2;
  localparam logic [55:0] LOW = 56'h1000_0000;
  localparam logic [55:0] UPP = 56'h2000_0000;
  localparam logic [6:0]  DEF = 7'h17;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_pma_region_checker_if #(
    .PADDR_W(PW), .NUM_CH(NC), .REG_IDX_W(RW)
  ) ifc ();

  lsu_pma_region_checker #(
    .PADDR_W(PW), .NUM_REGIONS(NR), .NUM_CH(NC),
    .DEF_IO_LOW(LOW), .DEF_IO_UPP(UPP),
    .DEF_ATTR(DEF), .REG_IDX_W(RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int checks = 0;
  int errors = 0;

  logic [55:0] m_base  [NR];
  logic [55:0] m_limit [NR];
  logic [6:0]  m_attr  [NR];
  logic [7*NC-1:0] exp_q;
  logic [7*NC-1:0] act;

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_base[r]  = '0;
      m_limit[r] = '0;
      m_attr[r]  = '0;
    end
    m_base[0]  = LOW;
    m_limit[0] = UPP;
    m_attr[0]  = 7'h4B;
  endtask

  task automatic idle();
    ifc.flush         = 1'b0;
    ifc.ch_vld_i      = '0;
    ifc.ch_dtlb_hit_i = '0;
    ifc.ch_paddr_i    = '0;
    ifc.ch_is_st_i    = '0;
    ifc.ch_is_amo_i   = '0;
    ifc.cfg_we_i      = 1'b0;
    ifc.cfg_idx_i     = '0;
    ifc.cfg_base_i    = '0;
    ifc.cfg_limit_i   = '0;
    ifc.cfg_attr_i    = '0;
  endtask

  task automatic set_ch(input int c, input logic v, input logic h,
                        input logic st, input logic amo,
                        input logic [55:0] pa);
    ifc.ch_vld_i[c]      = v;
    ifc.ch_dtlb_hit_i[c] = h;
    ifc.ch_is_st_i[c]    = st;
    ifc.ch_is_amo_i[c]   = amo;
    ifc.ch_paddr_i[c*PW +: PW] = pa;
  endtask

  task automatic cfg(input logic we, input int idx,
                     input logic [55:0] b, input logic [55:0] l,
                     input logic [6:0] a);
    ifc.cfg_we_i    = we;
    ifc.cfg_idx_i   = 2'(idx);
    ifc.cfg_base_i  = b;
    ifc.cfg_limit_i = l;
    ifc.cfg_attr_i  = a;
  endtask

  // Per channel: {vld, io, cacheable, fault, region[1:0], hit};
  // all zero when not valid.
  function automatic logic [7*NC-1:0] pack_act();
    logic [7*NC-1:0] p;
    p = '0;
    for (int c = 0; c < NC; c++) begin
      if (ifc.resp_vld_o[c] === 1'b1)
        p[c*7 +: 7] = {1'b1, ifc.resp_is_io_o[c],
                       ifc.resp_cacheable_o[c],
                       ifc.resp_fault_o[c],
                       ifc.resp_region_o[c*RW +: RW],
                       ifc.resp_hit_o[c]};
      else if (ifc.resp_vld_o[c] !== 1'b0)
        p[c*7 +: 7] = 7'bx;
    end
    return p;
  endfunction

  // Expected response from the model table as it stands before
  // the edge, then apply reset / config write to the model.
  task automatic cycle();
    logic [7*NC-1:0] e;
    e = '0;
    if (!rst) begin
      for (int c = 0; c < NC; c++) begin
        logic [55:0] pa;
        logic [6:0] a;
        logic [6:0] need;
        int idx;
        pa = ifc.ch_paddr_i[c*PW +: PW];
        idx = -1;
        for (int r = 0; r < NR; r++)
          if (idx < 0 && m_attr[r][6] &&
              pa >= m_base[r] && pa < m_limit[r])
            idx = r;
        a = (idx < 0) ? DEF : m_attr[idx];
        if (ifc.ch_is_amo_i[c])     need = 7'b0000111;
        else if (ifc.ch_is_st_i[c]) need = 7'b0000010;
        else                        need = 7'b0000001;
        if (ifc.ch_vld_i[c] && ifc.ch_dtlb_hit_i[c] && !ifc.flush)
          e[c*7 +: 7] = {1'b1, a[3], a[4] & ~a[3],
                         (a & need) != need,
                         (idx < 0) ? 2'd0 : 2'(idx),
                         idx >= 0};
      end
    end
    if (rst) model_reset();
    else if (ifc.cfg_we_i && !m_attr[ifc.cfg_idx_i][5]) begin
      m_base[ifc.cfg_idx_i]  = ifc.cfg_base_i;
      m_limit[ifc.cfg_idx_i] = ifc.cfg_limit_i;
      m_attr[ifc.cfg_idx_i]  = ifc.cfg_attr_i;
    end
    exp_q = e;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    set_ch(0, 1, 1, 0, 0, 56'h1000_0040);
    cycle();
    cycle();
    checks++;
    if ({ifc.resp_vld_o, ifc.resp_is_io_o, ifc.resp_cacheable_o,
         ifc.resp_fault_o, ifc.resp_region_o, ifc.resp_hit_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got vld=%b io=%b c=%b f=%b rg=%b h=%b want all 0",
               ifc.resp_vld_o, ifc.resp_is_io_o, ifc.resp_cacheable_o,
               ifc.resp_fault_o, ifc.resp_region_o, ifc.resp_hit_o);
    end
    rst = 1'b0;
    idle();
    #1;
    checks++;
    if (ifc.cfg_rdata_o !== {LOW, UPP, 7'h4B}) begin
      errors++;
      $display("FAIL reset_region0 got=%h want=%h",
               ifc.cfg_rdata_o, {LOW, UPP, 7'h4B});
    end
    ifc.cfg_idx_i = 2'd3;
    #1;
    checks++;
    if (ifc.cfg_rdata_o !== '0) begin
      errors++;
      $display("FAIL reset_region3 got=%h want=0", ifc.cfg_rdata_o);
    end
  endtask

  task automatic test_basic();
    idle();
    set_ch(0, 1, 1, 0, 0, 56'h1000_0040);
    cycle();
    act = pack_act();
    checks++;
    if (act[6:0] !== 7'b1100001) begin
      errors++;
      $display("FAIL io_load got=%b want=1100001", act[6:0]);
    end
    idle();
    set_ch(1, 1, 1, 1, 0, 56'h8000_0000);
    set_ch(0, 1, 1, 0, 1, 56'h1000_0000);
    cycle();
    act = pack_act();
    checks++;
    if (act[13:7] !== 7'b1010000) begin
      errors++;
      $display("FAIL unmatched_store got=%b want=1010000", act[13:7]);
    end
    checks++;
    if (act[6:0] !== 7'b1101001) begin
      errors++;
      $display("FAIL io_amo_fault got=%b want=1101001", act[6:0]);
    end
    checks++;
    if (act !== exp_q) begin
      errors++;
      $display("FAIL basic_model got=%b want=%b", act, exp_q);
    end
  endtask

  task automatic test_priority();
    idle();
    cfg(1, 1, 56'h1000_0000, 56'h1000_1000, 7'h51);
    cycle();
    idle();
    set_ch(0, 1, 1, 1, 0, 56'h1000_0800);
    cycle();
    act = pack_act();
    checks++;
    if (act[6:0] !== 7'b1100001) begin
      errors++;
      $display("FAIL prio_region0 got=%b want=1100001", act[6:0]);
    end
    idle();
    cfg(1, 0, LOW, UPP, 7'h00);
    cycle();
    idle();
    set_ch(0, 1, 1, 1, 0, 56'h1000_0800);
    cycle();
    act = pack_act();
    checks++;
    if (act[6:0] !== 7'b1011011) begin
      errors++;
      $display("FAIL prio_region1 got=%b want=1011011", act[6:0]);
    end
  endtask

  task automatic test_lock();
    idle();
    cfg(1, 2, 56'h3000_0000, 56'h4000_0000, 7'h63);
    cycle();
    cfg(1, 2, 56'h0, 56'h0, 7'h00);
    cycle();
    idle();
    ifc.cfg_idx_i = 2'd2;
    set_ch(0, 1, 1, 0, 0, 56'h3000_0100);
    #1;
    checks++;
    if (ifc.cfg_rdata_o !== {56'h3000_0000, 56'h4000_0000, 7'h63}) begin
      errors++;
      $display("FAIL lock_hold got=%h", ifc.cfg_rdata_o);
    end
    cycle();
    act = pack_act();
    checks++;
    if (act[6:0] !== 7'b1000101) begin
      errors++;
      $display("FAIL lock_region2_hit got=%b want=1000101", act[6:0]);
    end
    rst = 1'b1;
    cfg(1, 2, 56'h5, 56'h6, 7'h7F);
    ifc.flush = 1'b0;
    cycle();
    rst = 1'b0;
    idle();
    ifc.cfg_idx_i = 2'd2;
    #1;
    checks++;
    if (ifc.cfg_rdata_o !== '0) begin
      errors++;
      $display("FAIL lock_cleared got=%h want=0", ifc.cfg_rdata_o);
    end
    cfg(1, 2, 56'h40, 56'h80, 7'h41);
    cycle();
    idle();
    ifc.cfg_idx_i = 2'd2;
    #1;
    checks++;
    if (ifc.cfg_rdata_o !== {56'h40, 56'h80, 7'h41}) begin
      errors++;
      $display("FAIL unlock_write got=%h", ifc.cfg_rdata_o);
    end
  endtask

  task automatic test_flush();
    idle();
    ifc.flush = 1'b1;
    set_ch(0, 1, 1, 0, 0, 56'h1000_0040);
    set_ch(1, 1, 0, 0, 0, 56'h1000_0040);
    cycle();
    checks++;
    if (ifc.resp_vld_o !== 2'b00) begin
      errors++;
      $display("FAIL flush_drop got=%b want=00", ifc.resp_vld_o);
    end
    ifc.flush = 1'b0;
    cycle();
    checks++;
    if (ifc.resp_vld_o !== 2'b01) begin
      errors++;
      $display("FAIL after_flush got=%b want=01", ifc.resp_vld_o);
    end
    act = pack_act();
    checks++;
    if (act !== exp_q) begin
      errors++;
      $display("FAIL flush_model got=%b want=%b", act, exp_q);
    end
  endtask

  task automatic test_boundary();
    rst = 1'b1;
    idle();
    cycle();
    rst = 1'b0;
    set_ch(0, 1, 1, 0, 0, 56'h0FFF_FFFF);
    set_ch(1, 1, 1, 0, 0, 56'h1000_0000);
    cycle();
    checks++;
    if ({ifc.resp_vld_o, ifc.resp_is_io_o} !== 4'b1110) begin
      errors++;
      $display("FAIL bound_low got vld/io=%b want=1110",
               {ifc.resp_vld_o, ifc.resp_is_io_o});
    end
    set_ch(0, 1, 1, 0, 0, 56'h1FFF_FFFF);
    set_ch(1, 1, 1, 0, 0, 56'h2000_0000);
    cycle();
    checks++;
    if ({ifc.resp_vld_o, ifc.resp_is_io_o} !== 4'b1101) begin
      errors++;
      $display("FAIL bound_high got vld/io=%b want=1101",
               {ifc.resp_vld_o, ifc.resp_is_io_o});
    end
    idle();
    cfg(1, 0, LOW, 56'h1000_0100, 7'h4B);
    set_ch(0, 1, 1, 0, 0, 56'h1000_0200);
    cycle();
    checks++;
    if (ifc.resp_is_io_o[0] !== 1'b1 || ifc.resp_vld_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_same_cycle got io=%b want=1", ifc.resp_is_io_o[0]);
    end
    ifc.cfg_we_i = 1'b0;
    cycle();
    checks++;
    if (ifc.resp_is_io_o[0] !== 1'b0 || ifc.resp_hit_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_next_cycle got io=%b hit=%b want 0 0",
               ifc.resp_is_io_o[0], ifc.resp_hit_o[0]);
    end
  endtask

  function automatic logic [55:0] rnd_addr();
    logic [55:0] pts [6];
    pts[0] = 56'h0;
    pts[1] = 56'h1000_0000;
    pts[2] = 56'h1000_1000;
    pts[3] = 56'h2000_0000;
    pts[4] = 56'h3000_0000;
    pts[5] = 56'h8000_0000;
    return pts[$urandom_range(0, 5)] + 56'($urandom_range(0, 2)) - 56'd1;
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [6:0] a;
      idle();
      rst = ($urandom_range(0, 99) == 0);
      ifc.flush = ($urandom_range(0, 9) == 0);
      for (int c = 0; c < NC; c++)
        set_ch(c, 1'($urandom), ($urandom_range(0, 4) != 0),
               1'($urandom), ($urandom_range(0, 3) == 0), rnd_addr());
      a = 7'($urandom);
      a[5] = ($urandom_range(0, 7) == 0);
      a[6] = ($urandom_range(0, 3) != 0);
      cfg(($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
          rnd_addr(), rnd_addr(), a);
      cycle();
      act = pack_act();
      checks++;
      if (act !== exp_q) begin
        errors++;
        $display("FAIL rand_resp n=%0d got=%b want=%b", n, act, exp_q);
      end
      checks++;
      if (ifc.cfg_rdata_o !== {m_base[ifc.cfg_idx_i],
                               m_limit[ifc.cfg_idx_i],
                               m_attr[ifc.cfg_idx_i]}) begin
        errors++;
        $display("FAIL rand_rdata n=%0d idx=%0d got=%h", n,
                 ifc.cfg_idx_i, ifc.cfg_rdata_o);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_basic();
    test_priority();
    test_lock();
    test_flush();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
